// File: rtl/ysyx_25040109_axi_sram_if.sv
// AXI4 bus bundle between the crossbar SRAM port (master) and the SRAM responder (slave).
interface ysyx_25040109_axi_sram_if;
    // Read address channel
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    // Read data channel
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic [3:0]  rid;
    logic        rlast;
    // Write address channel
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic [3:0]  awid;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    // Write data channel
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    // Write response channel
    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;
    logic [3:0]  bid;

    modport master (
        output arvalid, araddr, arid, arlen, arsize, arburst, rready,
        output awvalid, awaddr, awid, awlen, awsize, awburst,
        output wvalid, wdata, wstrb, wlast, bready,
        input  arready, rvalid, rdata, rresp, rid, rlast,
        input  awready, wready, bvalid, bresp, bid
    );

    modport slave (
        input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
        input  awvalid, awaddr, awid, awlen, awsize, awburst,
        input  wvalid, wdata, wstrb, wlast, bready,
        output arready, rvalid, rdata, rresp, rid, rlast,
        output awready, wready, bvalid, bresp, bid
    );
endinterface

// File: rtl/ysyx_25040109_axi_sram.sv
// Word-addressed AXI4 SRAM responder: one transaction at a time, writes win over reads,
// INCR bursts with index wrap, programmable read/write latency, SLVERR on bad accesses.
module ysyx_25040109_axi_sram #(
    parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned RD_LAT      = 2,
    parameter int unsigned WR_LAT      = 1
) (
    input logic clk,
    input logic rst,
    ysyx_25040109_axi_sram_if.slave bus
);
    localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS);
    localparam logic [32:0] ADDR_END   = {1'b0, ADDR_BASE} + 33'(4 * DEPTH_WORDS);
    localparam logic [1:0]  RESP_OKAY  = 2'b00;
    localparam logic [1:0]  RESP_SLV   = 2'b10;
    // Counters count down to zero, so they are loaded with latency-1.
    localparam logic [3:0]  RD_CNT0    = (RD_LAT == 0) ? 4'd0 : 4'(RD_LAT - 1);
    localparam logic [3:0]  WR_CNT0    = (WR_LAT == 0) ? 4'd0 : 4'(WR_LAT - 1);

    typedef enum logic [2:0] {
        IDLE, RD_WAIT, RD_DATA, WR_DATA, WR_WAIT, WR_RESP
    } state_e;

    // Any start address the array cannot serve as a plain 32-bit INCR access.
    function automatic logic addr_err(input logic [31:0] addr, input logic [2:0] size,
                                      input logic [1:0] burst);
        return ({1'b0, addr} < {1'b0, ADDR_BASE}) || ({1'b0, addr} >= ADDR_END) ||
               (size != 3'b010) || (burst != 2'b01) || (addr[1:0] != 2'b00);
    endfunction

    // Word index of a byte address, folded into the array.
    function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] addr);
        return IDX_W'((addr - ADDR_BASE) >> 2);
    endfunction

    state_e           state_q;
    logic             rdy_q;      // IDLE and out of reset: address channels may handshake
    logic [3:0]       cnt_q;
    logic [3:0]       id_q;
    logic [7:0]       len_q;
    logic [8:0]       beat_q;     // wide enough to see write beats past awlen+1
    logic [IDX_W-1:0] idx_q;
    logic             err_q;

    logic             wready_q;
    logic             rvalid_q;
    logic             rlast_q;
    logic [31:0]      rdata_q;
    logic [1:0]       rresp_q;
    logic [3:0]       rid_q;
    logic             bvalid_q;
    logic [1:0]       bresp_q;
    logic [3:0]       bid_q;

    logic [31:0]      mem [DEPTH_WORDS];

    logic             ar_fire, aw_fire, w_fire, r_fire, b_fire;
    logic             ar_err, aw_err;
    logic [IDX_W-1:0] ar_idx, aw_idx, idx_nxt;
    logic             w_in_range, w_early, w_err_now, mem_we;
    logic [IDX_W-1:0] rd_src_idx;
    logic             rd_src_err;
    logic [31:0]      rd_word;

    assign bus.awready = rdy_q;
    assign bus.arready = rdy_q & ~bus.awvalid;
    assign bus.wready  = wready_q;
    assign bus.rvalid  = rvalid_q;
    assign bus.rlast   = rlast_q;
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = rresp_q;
    assign bus.rid     = rid_q;
    assign bus.bvalid  = bvalid_q;
    assign bus.bresp   = bresp_q;
    assign bus.bid     = bid_q;

    assign ar_fire = bus.arvalid & bus.arready;
    assign aw_fire = bus.awvalid & rdy_q;
    assign w_fire  = bus.wvalid & wready_q;
    assign r_fire  = rvalid_q & bus.rready;
    assign b_fire  = bvalid_q & bus.bready;

    assign ar_err  = addr_err(bus.araddr, bus.arsize, bus.arburst);
    assign aw_err  = addr_err(bus.awaddr, bus.awsize, bus.awburst);
    assign ar_idx  = addr_idx(bus.araddr);
    assign aw_idx  = addr_idx(bus.awaddr);
    assign idx_nxt = idx_q + 1'b1;   // natural wrap at DEPTH_WORDS-1

    // Beats past awlen+1 and a premature wlast beat are both refused and flagged.
    assign w_in_range = beat_q <= {1'b0, len_q};
    assign w_early    = bus.wlast && (beat_q < {1'b0, len_q});
    assign w_err_now  = err_q | ~w_in_range | w_early;
    assign mem_we     = (state_q == WR_DATA) && w_fire && !w_err_now;

    // Select which word the next R beat will present; a single read port serves all paths.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        rd_src_idx = idx_q;
        rd_src_err = err_q;
        if (state_q == IDLE) begin
            rd_src_idx = ar_idx;
            rd_src_err = ar_err;
        end else if (state_q == RD_DATA) begin
            rd_src_idx = idx_nxt;
        end
    end
    assign rd_word = rd_src_err ? 32'h0 : mem[rd_src_idx];

    // Storage array with per-byte write strobes.
    // NOTE: the array has no reset; contents must survive rst and a reset port would block RAM inference.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.wstrb[b]) mem[idx_q][8*b +: 8] <= bus.wdata[8*b +: 8];
            end
        end
    end

    // Transaction FSM with all handshake outputs registered.
    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rdy_q    <= 1'b0;
            cnt_q    <= 4'd0;
            id_q     <= 4'd0;
            len_q    <= 8'd0;
            beat_q   <= 9'd0;
            idx_q    <= '0;
            err_q    <= 1'b0;
            wready_q <= 1'b0;
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            rdata_q  <= 32'h0;
            rresp_q  <= RESP_OKAY;
            rid_q    <= 4'd0;
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
            bid_q    <= 4'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    rdy_q <= ~(aw_fire | ar_fire);
                    if (aw_fire) begin
                        state_q  <= WR_DATA;
                        wready_q <= 1'b1;
                        id_q     <= bus.awid;
                        len_q    <= bus.awlen;
                        idx_q    <= aw_idx;
                        err_q    <= aw_err;
                        beat_q   <= 9'd0;
                    end else if (ar_fire) begin
                        id_q   <= bus.arid;
                        len_q  <= bus.arlen;
                        idx_q  <= ar_idx;
                        err_q  <= ar_err;
                        beat_q <= 9'd0;
                        if (RD_LAT == 0) begin
                            state_q  <= RD_DATA;
                            rvalid_q <= 1'b1;
                            rdata_q  <= rd_word;
                            rresp_q  <= ar_err ? RESP_SLV : RESP_OKAY;
                            rid_q    <= bus.arid;
                            rlast_q  <= (bus.arlen == 8'd0);
                        end else begin
                            state_q <= RD_WAIT;
                            cnt_q   <= RD_CNT0;
                        end
                    end
                end
                RD_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q  <= RD_DATA;
                        rvalid_q <= 1'b1;
                        rdata_q  <= rd_word;
                        rresp_q  <= err_q ? RESP_SLV : RESP_OKAY;
                        rid_q    <= id_q;
                        rlast_q  <= (len_q == 8'd0);
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RD_DATA: begin
                    if (r_fire) begin
                        if (rlast_q) begin
                            state_q  <= IDLE;
                            rdy_q    <= 1'b1;
                            rvalid_q <= 1'b0;
                            rlast_q  <= 1'b0;
                            rdata_q  <= 32'h0;
                            rresp_q  <= RESP_OKAY;
                            rid_q    <= 4'd0;
                        end else begin
                            beat_q  <= beat_q + 9'd1;
                            idx_q   <= idx_nxt;
                            rdata_q <= rd_word;
                            rlast_q <= ((beat_q + 9'd1) == {1'b0, len_q});
                        end
                    end
                end
                WR_DATA: begin
                    if (w_fire) begin
                        idx_q <= idx_nxt;
                        if (beat_q != 9'h1FF) beat_q <= beat_q + 9'd1;
                        if (w_err_now) err_q <= 1'b1;
                        if (bus.wlast) begin
                            wready_q <= 1'b0;
                            if (WR_LAT == 0) begin
                                state_q  <= WR_RESP;
                                bvalid_q <= 1'b1;
                                bresp_q  <= w_err_now ? RESP_SLV : RESP_OKAY;
                                bid_q    <= id_q;
                            end else begin
                                state_q <= WR_WAIT;
                                cnt_q   <= WR_CNT0;
                            end
                        end
                    end
                end
                WR_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q  <= WR_RESP;
                        bvalid_q <= 1'b1;
                        bresp_q  <= err_q ? RESP_SLV : RESP_OKAY;
                        bid_q    <= id_q;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                WR_RESP: begin
                    if (b_fire) begin
                        state_q  <= IDLE;
                        rdy_q    <= 1'b1;
                        bvalid_q <= 1'b0;
                        bresp_q  <= RESP_OKAY;
                        bid_q    <= 4'd0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_25040109_axi_sram.sv
// Directed bench for the AXI SRAM responder (default RD_LAT=2, WR_LAT=1, base 0x8000_0000).
module tb_ysyx_25040109_axi_sram;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ysyx_25040109_axi_sram_if bus ();

    ysyx_25040109_axi_sram dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] rdat [8];
    logic [1:0]  rrsp [8];
    logic        rlst [8];
    logic [3:0]  rids [8];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.arvalid = 0; bus.araddr = 0; bus.arid = 0; bus.arlen = 0; bus.arsize = 3'b010; bus.arburst = 2'b01;
        bus.awvalid = 0; bus.awaddr = 0; bus.awid = 0; bus.awlen = 0; bus.awsize = 3'b010; bus.awburst = 2'b01;
        bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0;
        bus.rready = 0; bus.bready = 0;
    endtask

    task automatic aw_send(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int t = 0;
        bus.awvalid = 1; bus.awaddr = addr; bus.awid = id; bus.awlen = len;
        bus.awsize = size; bus.awburst = burst;
        #1;
        while (!bus.awready && t < 50) begin @(negedge clk); #1; t++; end
        check("aw_handshake", 32'(bus.awready), 1);
        @(negedge clk);
        bus.awvalid = 0;
    endtask

    task automatic w_send(input logic [31:0] data, input logic [3:0] strb, input logic last);
        int t = 0;
        bus.wvalid = 1; bus.wdata = data; bus.wstrb = strb; bus.wlast = last;
        #1;
        while (!bus.wready && t < 50) begin @(negedge clk); #1; t++; end
        check("w_handshake", 32'(bus.wready), 1);
        @(negedge clk);
        bus.wvalid = 0; bus.wlast = 0;
    endtask

    task automatic ar_send(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int t = 0;
        bus.arvalid = 1; bus.araddr = addr; bus.arid = id; bus.arlen = len;
        bus.arsize = size; bus.arburst = burst;
        #1;
        while (!bus.arready && t < 50) begin @(negedge clk); #1; t++; end
        check("ar_handshake", 32'(bus.arready), 1);
        @(negedge clk);
        bus.arvalid = 0;
    endtask

    // Counts cycles after the last W fire until bvalid, then takes the response.
    task automatic b_wait(output logic [1:0] resp, output logic [3:0] id, output int lat);
        lat = 0;
        bus.bready = 1;
        while (!bus.bvalid && lat < 50) begin @(negedge clk); lat++; end
        check("b_valid", 32'(bus.bvalid), 1);
        resp = bus.bresp;
        id   = bus.bid;
        @(negedge clk);
        bus.bready = 0;
    endtask

    task automatic r_wait(output int lat);
        lat = 0;
        while (!bus.rvalid && lat < 50) begin @(negedge clk); lat++; end
        check("r_valid", 32'(bus.rvalid), 1);
    endtask

    // Collects nb beats; with toggle set, rready alternates 1,0,1,0 over rvalid cycles.
    task automatic r_collect(input int nb, input bit toggle);
        int got = 0;
        int v = 0;
        int cyc = 0;
        bit stalled = 0;
        logic [31:0] held = 0;
        while (got < nb && cyc < 100) begin
            if (stalled) begin
                check("r_hold_valid", 32'(bus.rvalid), 1);
                check("r_hold_data", bus.rdata, held);
                stalled = 0;
            end
            if (bus.rvalid) begin
                bus.rready = toggle ? (v % 2 == 0) : 1'b1;
                v++;
                if (bus.rready) begin
                    rdat[got] = bus.rdata; rrsp[got] = bus.rresp;
                    rlst[got] = bus.rlast; rids[got] = bus.rid;
                    got++;
                end else begin
                    held = bus.rdata;
                    stalled = 1;
                end
            end else begin
                bus.rready = 0;
            end
            @(negedge clk);
            cyc++;
        end
        bus.rready = 0;
        check("r_beats", 32'(got), 32'(nb));
    endtask

    task automatic wr1(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                       output logic [1:0] resp);
        logic [3:0] id;
        int lat;
        aw_send(addr, 4'h1, 8'd0, 3'b010, 2'b01);
        w_send(data, strb, 1'b1);
        b_wait(resp, id, lat);
    endtask

    task automatic rd1(input logic [31:0] addr, output logic [31:0] data);
        int lat;
        ar_send(addr, 4'h1, 8'd0, 3'b010, 2'b01);
        r_wait(lat);
        r_collect(1, 1'b0);
        data = rdat[0];
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  resp;
        logic [3:0]  id;
        logic [31:0] d;
        int          lat;

        idle_inputs();
        rst = 1;
        repeat (3) @(negedge clk);
        check("rst_awready", 32'(bus.awready), 0);
        check("rst_arready", 32'(bus.arready), 0);
        check("rst_rvalid",  32'(bus.rvalid), 0);
        check("rst_wready",  32'(bus.wready), 0);
        check("rst_bvalid",  32'(bus.bvalid), 0);
        check("rst_rdata",   bus.rdata, 0);
        rst = 0;
        #1 check("awready_still_low", 32'(bus.awready), 0);
        @(negedge clk);
        check("awready_up", 32'(bus.awready), 1);
        check("arready_up", 32'(bus.arready), 1);

        // Single write then read
        aw_send(32'h8000_0010, 4'h5, 8'd0, 3'b010, 2'b01);
        w_send(32'hDEAD_BEEF, 4'hF, 1'b1);
        b_wait(resp, id, lat);
        check("wr_bresp", 32'(resp), 0);
        check("wr_bid", 32'(id), 5);
        check("wr_blat", 32'(lat), 1);
        ar_send(32'h8000_0010, 4'h3, 8'd0, 3'b010, 2'b01);
        r_wait(lat);
        check("rd_lat", 32'(lat), 2);
        r_collect(1, 1'b0);
        check("rd_data", rdat[0], 32'hDEAD_BEEF);
        check("rd_rlast", 32'(rlst[0]), 1);
        check("rd_rid", 32'(rids[0]), 3);
        check("rd_rresp", 32'(rrsp[0]), 0);

        // Byte strobes
        wr1(32'h8000_0020, 32'h1122_3344, 4'hF, resp);
        wr1(32'h8000_0020, 32'hAABB_CCDD, 4'b0101, resp);
        check("strb_bresp", 32'(resp), 0);
        rd1(32'h8000_0020, d);
        check("strb_data", d, 32'h11BB_33DD);

        // INCR burst write of 4 words, then burst read with rready toggling
        aw_send(32'h8000_0000, 4'h2, 8'd3, 3'b010, 2'b01);
        for (int i = 0; i < 4; i++) w_send(32'hA5A5_0000 + 32'(i), 4'hF, i == 3);
        b_wait(resp, id, lat);
        check("bw_bresp", 32'(resp), 0);
        ar_send(32'h8000_0000, 4'h7, 8'd3, 3'b010, 2'b01);
        r_wait(lat);
        r_collect(4, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check("br_data", rdat[i], 32'hA5A5_0000 + 32'(i));
            check("br_rlast", 32'(rlst[i]), (i == 3) ? 1 : 0);
            check("br_rid", 32'(rids[i]), 7);
        end

        // Wrap from index 1023 to index 0
        aw_send(32'h8000_0FFC, 4'h4, 8'd1, 3'b010, 2'b01);
        w_send(32'h0000_00C1, 4'hF, 1'b0);
        w_send(32'h0000_00C2, 4'hF, 1'b1);
        b_wait(resp, id, lat);
        check("wrap_bresp", 32'(resp), 0);
        ar_send(32'h8000_0FFC, 4'h4, 8'd1, 3'b010, 2'b01);
        r_wait(lat);
        r_collect(2, 1'b0);
        check("wrap_d0", rdat[0], 32'h0000_00C1);
        check("wrap_d1", rdat[1], 32'h0000_00C2);
        check("wrap_rlast", 32'({rlst[0], rlst[1]}), 32'b01);
        rd1(32'h8000_0000, d);
        check("wrap_idx0", d, 32'h0000_00C2);

        // Out-of-range read: two SLVERR beats of zero
        ar_send(32'h1000_0000, 4'h2, 8'd1, 3'b010, 2'b01);
        r_wait(lat);
        r_collect(2, 1'b0);
        check("oor_d0", rdat[0], 0);
        check("oor_d1", rdat[1], 0);
        check("oor_resp", 32'({rrsp[0], rrsp[1]}), 32'b1010);
        check("oor_rlast", 32'({rlst[0], rlst[1]}), 32'b01);

        // Bad size write: SLVERR, memory unchanged
        aw_send(32'h8000_0010, 4'h6, 8'd0, 3'b001, 2'b01);
        w_send(32'h1234_5678, 4'hF, 1'b1);
        b_wait(resp, id, lat);
        check("size_bresp", 32'(resp), 2);
        rd1(32'h8000_0010, d);
        check("size_nowrite", d, 32'hDEAD_BEEF);

        // Early wlast on a len-3 burst: SLVERR, memory unchanged
        wr1(32'h8000_0030, 32'h3030_3030, 4'hF, resp);
        aw_send(32'h8000_0030, 4'h8, 8'd3, 3'b010, 2'b01);
        w_send(32'h5555_5555, 4'hF, 1'b1);
        b_wait(resp, id, lat);
        check("early_bresp", 32'(resp), 2);
        rd1(32'h8000_0030, d);
        check("early_nowrite", d, 32'h3030_3030);

        // Extra beat past awlen+1: first beat written, second refused, SLVERR
        aw_send(32'h8000_0040, 4'h1, 8'd1, 3'b010, 2'b01);
        w_send(32'h4040_4040, 4'hF, 1'b0);
        w_send(32'h4444_4444, 4'hF, 1'b1);
        b_wait(resp, id, lat);
        aw_send(32'h8000_0040, 4'h1, 8'd0, 3'b010, 2'b01);
        w_send(32'h1111_1111, 4'hF, 1'b0);
        w_send(32'h2222_2222, 4'hF, 1'b1);
        b_wait(resp, id, lat);
        check("extra_bresp", 32'(resp), 2);
        ar_send(32'h8000_0040, 4'h1, 8'd1, 3'b010, 2'b01);
        r_wait(lat);
        r_collect(2, 1'b0);
        check("extra_d0", rdat[0], 32'h1111_1111);
        check("extra_d1", rdat[1], 32'h4444_4444);

        // Simultaneous AR and AW: write first, AR accepted right after B fire
        bus.awvalid = 1; bus.awaddr = 32'h8000_0050; bus.awid = 4'h9; bus.awlen = 0;
        bus.awsize = 3'b010; bus.awburst = 2'b01;
        bus.arvalid = 1; bus.araddr = 32'h8000_0050; bus.arid = 4'hA; bus.arlen = 0;
        bus.arsize = 3'b010; bus.arburst = 2'b01;
        #1;
        check("prio_arready", 32'(bus.arready), 0);
        check("prio_awready", 32'(bus.awready), 1);
        @(negedge clk);
        bus.awvalid = 0;
        #1 check("prio_ar_blocked", 32'(bus.arready), 0);
        w_send(32'h7777_7777, 4'hF, 1'b1);
        b_wait(resp, id, lat);
        check("prio_bresp", 32'(resp), 0);
        check("prio_bid", 32'(id), 9);
        #1 check("prio_ar_after_b", 32'(bus.arready), 1);
        @(negedge clk);
        bus.arvalid = 0;
        r_wait(lat);
        check("prio_rlat", 32'(lat), 2);
        r_collect(1, 1'b0);
        check("prio_rdata", rdat[0], 32'h7777_7777);
        check("prio_rid", 32'(rids[0]), 32'hA);

        // Reset while in RD_DATA
        ar_send(32'h8000_0010, 4'hC, 8'd0, 3'b010, 2'b01);
        r_wait(lat);
        rst = 1;
        @(negedge clk);
        check("mrst_rvalid", 32'(bus.rvalid), 0);
        check("mrst_rdata", bus.rdata, 0);
        check("mrst_rlast", 32'(bus.rlast), 0);
        check("mrst_rid", 32'(bus.rid), 0);
        check("mrst_arready", 32'(bus.arready), 0);
        rst = 0;
        @(negedge clk);
        check("mrst_awready_up", 32'(bus.awready), 1);
        rd1(32'h8000_0010, d);
        check("mrst_mem_kept", d, 32'hDEAD_BEEF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
